mul_arbiter: RTL and testbench



---
 rtl/mul_arbiter.sv | 114 +++++++++++
 tb/tb_mul_arbiter.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mul_arbiter.sv
// Round-robin front end that shares one multiplier between two requesters.
// Latches operands, runs the level start/done handshake and aborts jobs that overrun.
module mul_arbiter #(
  parameter int DW          = 16,
  parameter int RW          = 32,
  parameter int TIMEOUT_CYC = 64,
  parameter int CW          = 7
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req0,
  input  logic [DW-1:0] src1_0,
  input  logic [DW-1:0] src2_0,
  output logic          ack0,
  output logic [RW-1:0] res0,
  output logic          res_valid0,
  output logic          err0,
  input  logic          req1,
  input  logic [DW-1:0] src1_1,
  input  logic [DW-1:0] src2_1,
  output logic          ack1,
  output logic [RW-1:0] res1,
  output logic          res_valid1,
  output logic          err1,
  output logic [DW-1:0] mul_src1,
  output logic [DW-1:0] mul_src2,
  output logic          mul_start,
  input  logic [RW-1:0] mul_res,
  input  logic          mul_done,
  output logic          busy
);

  typedef enum logic [1:0] {IDLE, ISSUE, GAP} state_t;

  localparam logic [CW-1:0] LAST_CNT = CW'(TIMEOUT_CYC - 1);

  state_t        state;
  logic          last_grant;
  logic          grant_id;
  logic [CW-1:0] cnt;
  logic          gnt_any;
  logic          gnt_port;

  // On contention the port that was not served last wins.
  always_comb begin
    gnt_any  = req0 | req1;
    gnt_port = req1;
    if (req0 && req1) gnt_port = ~last_grant;
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      last_grant <= 1'b1;
      grant_id   <= 1'b0;
      cnt        <= '0;
      ack0       <= 1'b0;
      ack1       <= 1'b0;
      res0       <= '0;
      res1       <= '0;
      res_valid0 <= 1'b0;
      res_valid1 <= 1'b0;
      err0       <= 1'b0;
      err1       <= 1'b0;
      mul_src1   <= '0;
      mul_src2   <= '0;
      mul_start  <= 1'b0;
    end else begin
      ack0       <= 1'b0;
      ack1       <= 1'b0;
      res_valid0 <= 1'b0;
      res_valid1 <= 1'b0;
      case (state)
        IDLE: begin
          if (gnt_any) begin
            mul_src1  <= gnt_port ? src1_1 : src1_0;
            mul_src2  <= gnt_port ? src2_1 : src2_0;
            ack0      <= ~gnt_port;
            ack1      <= gnt_port;
            mul_start <= 1'b1;
            grant_id  <= gnt_port;
            cnt       <= '0;
            state     <= ISSUE;
          end
        end
        ISSUE: begin
          // A done on the timeout edge still returns the real product.
          if (mul_done || cnt == LAST_CNT) begin
            if (grant_id) begin
              res1       <= mul_done ? mul_res : '0;
              err1       <= ~mul_done;
              res_valid1 <= 1'b1;
            end else begin
              res0       <= mul_done ? mul_res : '0;
              err0       <= ~mul_done;
              res_valid0 <= 1'b1;
            end
            mul_start  <= 1'b0;
            last_grant <= grant_id;
            state      <= GAP;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        GAP:     state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_mul_arbiter.sv
// Scoreboard bench for mul_arbiter: directed jobs push expected grants/results,
// a negedge monitor pops and compares whenever the DUT pulses ack or res_valid.
module tb_mul_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req0 = 1'b0, req1 = 1'b0;
  logic [15:0] src1_0 = '0, src2_0 = '0, src1_1 = '0, src2_1 = '0;
  logic        ack0, ack1, res_valid0, res_valid1, err0, err1;
  logic [31:0] res0, res1;
  logic [15:0] mul_src1, mul_src2;
  logic        mul_start, busy;
  logic [31:0] mul_res = '0;
  logic        mul_done = 1'b0;

  typedef struct {logic port; logic [15:0] a; logic [15:0] b;} gnt_t;
  typedef struct {logic port; logic [31:0] res; logic err;} res_t;

  gnt_t gnt_q[$];
  res_t res_q[$];
  int   tests = 0;
  int   fails = 0;
  int   mdl_lat = 0;
  int   mdl_cnt = 0;
  logic force_done = 1'b0;
  logic [31:0] last_res [2];
  logic        last_err [2];

  mul_arbiter #(.DW(16), .RW(32), .TIMEOUT_CYC(64), .CW(7)) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .src1_0(src1_0), .src2_0(src2_0), .ack0(ack0), .res0(res0),
    .res_valid0(res_valid0), .err0(err0),
    .req1(req1), .src1_1(src1_1), .src2_1(src2_1), .ack1(ack1), .res1(res1),
    .res_valid1(res_valid1), .err1(err1),
    .mul_src1(mul_src1), .mul_src2(mul_src2), .mul_start(mul_start),
    .mul_res(mul_res), .mul_done(mul_done), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Multiplier stand-in: raises done mdl_lat cycles after start rises (0 = never).
  always @(negedge clk) begin
    if (mul_start) begin
      mdl_cnt = mdl_cnt + 1;
      if (mdl_lat != 0 && mdl_cnt == mdl_lat) begin
        mul_done = 1'b1;
        mul_res  = 32'($signed(mul_src1) * $signed(mul_src2));
      end
    end else begin
      mdl_cnt  = 0;
      mul_done = force_done;
      if (force_done) mul_res = 32'h1234_5678;
    end
  end

  // Monitor
  always @(negedge clk or posedge rst) begin
    if (rst) begin
      last_res[0] = '0; last_res[1] = '0;
      last_err[0] = 1'b0; last_err[1] = 1'b0;
    end else begin
      if (ack0 || ack1) begin
        check("ack_expected", 64'(gnt_q.size() > 0), 1);
        if (gnt_q.size() > 0) begin
          gnt_t g;
          g = gnt_q.pop_front();
          check("ack_port", {ack1, ack0}, g.port ? 2'b10 : 2'b01);
          check("ack_src", {mul_src1, mul_src2}, {g.a, g.b});
          check("ack_start", mul_start, 1);
        end
      end
      if (res_valid0 || res_valid1) begin
        check("res_expected", 64'(res_q.size() > 0), 1);
        if (res_q.size() > 0) begin
          res_t r;
          r = res_q.pop_front();
          check("res_port", {res_valid1, res_valid0}, r.port ? 2'b10 : 2'b01);
          check("res_value", r.port ? res1 : res0, r.res);
          check("res_err", r.port ? err1 : err0, r.err);
          check("res_other", r.port ? {err0, res0} : {err1, res1},
                {last_err[!r.port], last_res[!r.port]});
          last_res[r.port] = r.res;
          last_err[r.port] = r.err;
        end
      end
    end
  end

  task automatic expect_job(input logic p, input logic [15:0] a, input logic [15:0] b,
                            input logic [31:0] r, input logic e, input bit with_res);
    gnt_t g;
    res_t x;
    g.port = p; g.a = a; g.b = b;
    gnt_q.push_back(g);
    if (with_res) begin
      x.port = p; x.res = r; x.err = e;
      res_q.push_back(x);
    end
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_flags"}, {ack0, ack1, res_valid0, res_valid1, err0, err1, mul_start, busy}, 8'h00);
    check({tag, "_res"}, {res0, res1}, 64'h0);
    check({tag, "_src"}, {mul_src1, mul_src2}, 32'h0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; req0 = 1'b0; req1 = 1'b0;
    gnt_q.delete(); res_q.delete();
    repeat (2) @(negedge clk);
    check_zero("rst");
    rst = 1'b0;
  endtask

  task automatic issue(input logic p, input logic [15:0] a, input logic [15:0] b);
    int n;
    @(negedge clk);
    if (p) begin req1 = 1'b1; src1_1 = a; src2_1 = b; end
    else   begin req0 = 1'b1; src1_0 = a; src2_0 = b; end
    n = 0;
    do begin @(negedge clk); n++; end while (!(p ? ack1 : ack0) && n < 200);
    check("ack_wait", p ? ack1 : ack0, 1);
    if (p) req1 = 1'b0; else req0 = 1'b0;
  endtask

  // Returns how many sampled cycles mul_start was high, starting at the ack cycle.
  task automatic wait_res(input logic p, output int start_cyc);
    int n;
    start_cyc = 1;
    n = 0;
    forever begin
      @(negedge clk);
      n++;
      if ((p ? res_valid1 : res_valid0) || n >= 300) break;
      start_cyc += int'(mul_start);
    end
    check("res_wait", p ? res_valid1 : res_valid0, 1);
    check("gap_start", mul_start, 0);
    check("gap_busy", busy, 1);
    @(negedge clk);
    check("idle_busy", busy, 0);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((res_q.size() != 0 || gnt_q.size() != 0 || busy) && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check("drain", 64'(res_q.size() + gnt_q.size()), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int cyc;
    int n;
    int acks;

    do_reset();

    // Single op on port 0: 6 * -5
    mdl_lat = 18;
    expect_job(1'b0, 16'h0006, 16'hFFFB, 32'hFFFF_FFE2, 1'b0, 1);
    issue(1'b0, 16'h0006, 16'hFFFB);
    wait_res(1'b0, cyc);
    check("single_start_cyc", cyc, 18);

    // Simultaneous requests right after reset: port 0 first
    do_reset();
    mdl_lat = 6;
    expect_job(1'b0, 16'h0003, 16'h0004, 32'h0000_000C, 1'b0, 1);
    expect_job(1'b1, 16'h8000, 16'h0002, 32'hFFFF_0000, 1'b0, 1);
    @(negedge clk);
    req0 = 1'b1; src1_0 = 16'h0003; src2_0 = 16'h0004;
    req1 = 1'b1; src1_1 = 16'h8000; src2_1 = 16'h0002;
    n = 0;
    while ((req0 || req1) && n < 300) begin
      @(negedge clk);
      n++;
      if (ack0) req0 = 1'b0;
      if (ack1) req1 = 1'b0;
    end
    drain();

    // Fairness: both held for four jobs, grants alternate 0,1,0,1
    mdl_lat = 3;
    for (int i = 0; i < 2; i++) begin
      expect_job(1'b0, 16'h0007, 16'h0009, 32'h0000_003F, 1'b0, 1);
      expect_job(1'b1, 16'hFFFE, 16'h0003, 32'hFFFF_FFFA, 1'b0, 1);
    end
    @(negedge clk);
    req0 = 1'b1; src1_0 = 16'h0007; src2_0 = 16'h0009;
    req1 = 1'b1; src1_1 = 16'hFFFE; src2_1 = 16'h0003;
    acks = 0;
    n = 0;
    while (acks < 4 && n < 500) begin
      @(negedge clk);
      n++;
      if (ack0 || ack1) acks++;
    end
    req0 = 1'b0; req1 = 1'b0;
    check("fair_acks", acks, 4);
    drain();

    // Timeout on port 0, then a normal job on port 1
    mdl_lat = 0;
    expect_job(1'b0, 16'h0005, 16'h0005, 32'h0, 1'b1, 1);
    issue(1'b0, 16'h0005, 16'h0005);
    wait_res(1'b0, cyc);
    check("timeout_start_cyc", cyc, 64);
    mdl_lat = 5;
    expect_job(1'b1, 16'h0002, 16'h0003, 32'h0000_0006, 1'b0, 1);
    issue(1'b1, 16'h0002, 16'h0003);
    wait_res(1'b1, cyc);

    // Reset in ISSUE: outputs clear without a clock edge, job abandoned
    mdl_lat = 0;
    expect_job(1'b0, 16'h0011, 16'h0022, 32'h0, 1'b0, 0);
    issue(1'b0, 16'h0011, 16'h0022);
    repeat (5) @(negedge clk);
    check("midop_busy", busy, 1);
    #2 rst = 1'b1;
    #1 check_zero("async_rst");
    @(negedge clk);
    gnt_q.delete(); res_q.delete();
    rst = 1'b0;
    force_done = 1'b1;
    repeat (3) @(negedge clk);
    force_done = 1'b0;
    check("late_done_busy", busy, 0);
    check("late_done_valid", {res_valid0, res_valid1}, 2'b00);
    mdl_lat = 4;
    expect_job(1'b1, 16'h0010, 16'hFFF0, 32'hFFFF_FF00, 1'b0, 1);
    issue(1'b1, 16'h0010, 16'hFFF0);
    wait_res(1'b1, cyc);

    // Done lands on the timeout edge: product wins, err stays 0
    mdl_lat = 64;
    expect_job(1'b0, 16'h0100, 16'h0100, 32'h0001_0000, 1'b0, 1);
    issue(1'b0, 16'h0100, 16'h0100);
    wait_res(1'b0, cyc);
    check("collide_start_cyc", cyc, 64);

    drain();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
